// File: rtl/img_pipe_pkg.sv
// Shared image-pipeline constants: pixel format, line geometry, credit sizing
// and the feed scheduler state encoding.
package img_pipe_pkg;

    localparam int INTEGER_BITS     = 8;
    localparam int FIXED_POINT_BITS = 4;
    localparam int DATA_W           = INTEGER_BITS + FIXED_POINT_BITS;
    localparam int LINE_WIDTH       = 512;
    localparam int NUM_LINE_BUFFERS = 4;
    localparam int MAX_LINES        = 512;
    localparam int LINE_CNT_W       = $clog2(MAX_LINES + 1);
    localparam int PIX_CNT_W        = $clog2(LINE_WIDTH);
    localparam int CREDIT_W         = $clog2(NUM_LINE_BUFFERS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/line_credit_counter.sv
// Saturating up/down credit counter: load restores the maximum, simultaneous
// inc and dec cancel, and the count never leaves [0, MAX_COUNT].
module line_credit_counter
    import img_pipe_pkg::*;
#(
    parameter int MAX_COUNT = NUM_LINE_BUFFERS,
    parameter int CNT_W     = CREDIT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_load,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_load) begin
            count <= MAX_VAL;
        end else if (i_inc && !i_dec && (count != MAX_VAL)) begin
            count <= count + CNT_W'(1);
        end else if (i_dec && !i_inc && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign o_count = count;
    assign o_zero  = (count == '0);

endmodule

// File: rtl/line_feed_scheduler.sv
// Credit-based pixel feeder for the 4-line-buffer 3x3 window generator.
// Optional feature macro BOTTOM_PAD_EN: append one all-zero line after the frame.
module line_feed_scheduler
    import img_pipe_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [LINE_CNT_W-1:0] i_frame_lines,
    input  logic [DATA_W-1:0]     i_src_data,
    input  logic                  i_src_valid,
    output logic                  o_src_ready,
    output logic [DATA_W-1:0]     o_pixel_data,
    output logic                  o_pixel_data_valid,
    input  logic                  i_intr,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [LINE_CNT_W-1:0] o_rows_out
);

    localparam logic [LINE_CNT_W-1:0] MIN_LINES_V = LINE_CNT_W'(3);
    localparam logic [LINE_CNT_W-1:0] MAX_LINES_V = LINE_CNT_W'(MAX_LINES);
    localparam logic [PIX_CNT_W-1:0]  LAST_PIX    = PIX_CNT_W'(LINE_WIDTH - 1);
    localparam logic [CREDIT_W-1:0]   FULL_CRED   = CREDIT_W'(NUM_LINE_BUFFERS);
`ifdef BOTTOM_PAD_EN
    localparam logic [LINE_CNT_W-1:0] ROW_DEFICIT = LINE_CNT_W'(1);
`else
    localparam logic [LINE_CNT_W-1:0] ROW_DEFICIT = LINE_CNT_W'(2);
`endif

    sched_state_t          state, state_nxt;
    logic [LINE_CNT_W-1:0] frame_lines;
    logic [LINE_CNT_W-1:0] lines_sent;
    logic [LINE_CNT_W-1:0] rows_out;
    logic [PIX_CNT_W-1:0]  pix_cnt;
    logic                  err_q, err_nxt;
    logic                  pad_active;
    logic [CREDIT_W-1:0]   credits;
    logic                  cred_zero, cred_full;
    logic                  legal_lines, start_ok;
    logic                  src_ready, src_fire, pad_fire, pix_fire;
    logic                  line_end, last_real_line, intr_ok;

    assign cred_full      = (credits == FULL_CRED);
    assign legal_lines    = (i_frame_lines >= MIN_LINES_V) && (i_frame_lines <= MAX_LINES_V);
    assign start_ok       = (state == IDLE) && i_start && legal_lines;
    assign src_ready      = (state == SEND) && !cred_zero && !pad_active;
    assign src_fire       = i_src_valid && src_ready;
    assign pad_fire       = pad_active && !cred_zero;
    assign pix_fire       = src_fire || pad_fire;
    assign line_end       = pix_fire && (pix_cnt == LAST_PIX);
    assign last_real_line = line_end && !pad_active
                            && ((lines_sent + LINE_CNT_W'(1)) == frame_lines);
    // A row pulse at full credits is only real if the same cycle spends a credit.
    assign intr_ok        = i_intr && ((state == SEND) || (state == DRAIN))
                            && (!cred_full || line_end);

    line_credit_counter #(
        .MAX_COUNT (NUM_LINE_BUFFERS),
        .CNT_W     (CREDIT_W)
    ) u_credits (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (intr_ok),
        .i_dec   (line_end),
        .i_load  (state == DONE),
        .o_count (credits),
        .o_zero  (cred_zero)
    );

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    if (legal_lines) state_nxt = SEND;
                    else             err_nxt   = 1'b1;
                end
            end
            SEND: begin
`ifdef BOTTOM_PAD_EN
                if (pad_fire && line_end) state_nxt = DRAIN;
`else
                if (last_real_line) state_nxt = DRAIN;
`endif
            end
            DRAIN: begin
                if (rows_out >= (frame_lines - ROW_DEFICIT)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            err_q       <= 1'b0;
            frame_lines <= '0;
            lines_sent  <= '0;
            rows_out    <= '0;
            pix_cnt     <= '0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
            if (start_ok) begin
                frame_lines <= i_frame_lines;
                lines_sent  <= '0;
                rows_out    <= '0;
                pix_cnt     <= '0;
            end else begin
                if (pix_fire)                 pix_cnt    <= pix_cnt + PIX_CNT_W'(1);
                if (line_end && !pad_active)  lines_sent <= lines_sent + LINE_CNT_W'(1);
                if (intr_ok)                  rows_out   <= rows_out + LINE_CNT_W'(1);
            end
        end
    end

`ifdef BOTTOM_PAD_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)                     pad_active <= 1'b0;
        else if (last_real_line)       pad_active <= 1'b1;
        else if (pad_fire && line_end) pad_active <= 1'b0;
    end
`else
    assign pad_active = 1'b0;
`endif

    assign o_src_ready        = src_ready;
    assign o_pixel_data       = pad_active ? '0 : i_src_data;
    assign o_pixel_data_valid = pix_fire;
    assign o_busy             = (state != IDLE);
    assign o_done             = (state == DONE);
    assign o_err              = err_q;
    assign o_rows_out         = rows_out;

endmodule

// File: tb/tb_line_feed_scheduler.sv
// Scoreboard bench for line_feed_scheduler: source pushes expected pixels, a
// forked monitor pops and compares every strobe and every done pulse.
`timescale 1ns/1ps
module tb_line_feed_scheduler;
    import img_pipe_pkg::*;

`ifdef BOTTOM_PAD_EN
    localparam int PAD_LINES = 1;
`else
    localparam int PAD_LINES = 0;
`endif

    logic                  i_clk = 1'b0;
    logic                  i_rst;
    logic                  i_start;
    logic [LINE_CNT_W-1:0] i_frame_lines;
    logic [DATA_W-1:0]     i_src_data;
    logic                  i_src_valid;
    logic                  o_src_ready;
    logic [DATA_W-1:0]     o_pixel_data;
    logic                  o_pixel_data_valid;
    logic                  i_intr;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_err;
    logic [LINE_CNT_W-1:0] o_rows_out;

    line_feed_scheduler dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_start            (i_start),
        .i_frame_lines      (i_frame_lines),
        .i_src_data         (i_src_data),
        .i_src_valid        (i_src_valid),
        .o_src_ready        (o_src_ready),
        .o_pixel_data       (o_pixel_data),
        .o_pixel_data_valid (o_pixel_data_valid),
        .i_intr             (i_intr),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_err              (o_err),
        .o_rows_out         (o_rows_out)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    int first_cyc = 0;
    int last_cyc  = 0;
    bit mark_first = 1'b0;
    bit abort = 1'b0;
    bit src_active = 1'b0;
    logic [DATA_W-1:0] exp_q[$];
    int exp_rows_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event outside expectation (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_intr();
        i_intr = 1'b1;
        tick();
        i_intr = 1'b0;
    endtask

    task automatic wait_xfer(input int target, input string name);
        int t = 0;
        while (xfer_cnt < target && t < 20000) begin
            tick();
            t++;
        end
        check(name, xfer_cnt, target);
    endtask

    task automatic wait_done(input int target, input string name);
        int t = 0;
        while (done_cnt < target && t < 200) begin
            tick();
            t++;
        end
        check(name, done_cnt, target);
    endtask

    task automatic start_frame(input int lines, input bit expect_err);
        i_frame_lines = LINE_CNT_W'(lines);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("start_err", int'(o_err), int'(expect_err));
        check("start_busy", int'(o_busy), int'(!expect_err));
    endtask

    task automatic source(input int n, input int gap_pct, input logic [DATA_W-1:0] seed);
        logic [DATA_W-1:0] d;
        bit hs;
        int tmo;
        src_active = 1'b1;
        for (int i = 0; i < n && !abort; i++) begin
            d = seed ^ DATA_W'(i * 5);
            exp_q.push_back(d);
            i_src_data = d;
            while (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
                i_src_valid = 1'b0;
                tick();
            end
            i_src_valid = 1'b1;
            hs = 1'b0;
            tmo = 0;
            while (!hs && !abort) begin
                @(negedge i_clk);
                hs = o_src_ready;
                tick();
                tmo++;
                if (tmo > 20000) begin
                    fail_now("src_handshake_timeout");
                    abort = 1'b1;
                end
            end
        end
        if (!abort) begin
            for (int i = 0; i < PAD_LINES * LINE_WIDTH; i++) exp_q.push_back('0);
        end
        i_src_valid = 1'b0;
        src_active = 1'b0;
    endtask

    task automatic run_frame(input int lines, input int gap, input logic [DATA_W-1:0] seed,
                             input bit check_b2b);
        int rows = lines - 2 + PAD_LINES;
        int total = (lines + PAD_LINES) * LINE_WIDTH;
        xfer_cnt = 0;
        done_cnt = 0;
        mark_first = 1'b1;
        exp_rows_q.push_back(rows);
        start_frame(lines, 1'b0);
        fork
            source(lines * LINE_WIDTH, gap, seed);
        join_none
        for (int r = 0; r < rows; r++) begin
            wait_xfer((r + 3) * LINE_WIDTH, "xfer_row_trigger");
            pulse_intr();
        end
        wait_xfer(total, "xfer_total");
        if (check_b2b && PAD_LINES == 0) check("b2b_span", last_cyc - first_cyc, total - 1);
        wait_done(1, "frame_done");
        repeat (3) tick();
        check("done_once", done_cnt, 1);
        check("busy_after_done", int'(o_busy), 0);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [DATA_W-1:0] e;
        int t;
        i_rst = 1'b1;
        i_start = 1'b0;
        i_intr = 1'b0;
        i_frame_lines = '0;
        i_src_data = '0;
        i_src_valid = 1'b1;

        fork
            forever begin
                @(negedge i_clk);
                if (o_pixel_data_valid) begin
                    if (mark_first) begin
                        first_cyc = cyc;
                        mark_first = 1'b0;
                    end
                    last_cyc = cyc;
                    xfer_cnt++;
                    if (exp_q.size() == 0) fail_now("pixel_unexpected");
                    else begin
                        e = exp_q.pop_front();
                        check("pixel_data", int'(o_pixel_data), int'(e));
                    end
                end
                if (o_done) begin
                    done_cnt++;
                    if (exp_rows_q.size() == 0) fail_now("done_unexpected");
                    else check("rows_at_done", int'(o_rows_out), exp_rows_q.pop_front());
                end
            end
        join_none

        repeat (3) tick();
        check("rst_ready", int'(o_src_ready), 0);
        check("rst_strobe", int'(o_pixel_data_valid), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_err", int'(o_err), 0);
        check("rst_rows", int'(o_rows_out), 0);
        i_rst = 1'b0;
        i_src_valid = 1'b0;
        tick();

`ifndef BOTTOM_PAD_EN
        // Frame of 5 lines: 4 lines stream, stall at zero credits, 5th after a row pulse.
        xfer_cnt = 0; done_cnt = 0; mark_first = 1'b1;
        exp_rows_q.push_back(3);
        start_frame(5, 1'b0);
        fork
            source(5 * LINE_WIDTH, 0, 12'h100);
        join_none
        wait_xfer(2048, "t1_four_lines");
        check("t1_b2b", last_cyc - first_cyc, 2047);
        repeat (5) tick();
        check("t1_stall_ready", int'(o_src_ready), 0);
        check("t1_stall_count", xfer_cnt, 2048);
        check("t1_stall_busy", int'(o_busy), 1);
        pulse_intr();
        check("t1_rows_1", int'(o_rows_out), 1);
        wait_xfer(2560, "t1_line5");
        tick();
        check("t1_drain_ready", int'(o_src_ready), 0);
        check("t1_no_early_done", done_cnt, 0);
        pulse_intr();
        pulse_intr();
        wait_done(1, "t1_done");
        repeat (3) tick();

        // Row pulse coincident with the end of line 2: credits unchanged, no bubble.
        xfer_cnt = 0; done_cnt = 0; mark_first = 1'b1;
        exp_rows_q.push_back(3);
        start_frame(5, 1'b0);
        fork
            source(5 * LINE_WIDTH, 0, 12'h3A5);
        join_none
        wait_xfer(1023, "t2_reach_eol");
        pulse_intr();
        check("t2_rows_1", int'(o_rows_out), 1);
        wait_xfer(2560, "t2_all_lines");
        check("t2_b2b", last_cyc - first_cyc, 2559);
        pulse_intr();
        pulse_intr();
        wait_done(1, "t2_done");
        repeat (3) tick();
`endif

        // Illegal line counts, then a legal frame with a mid-frame start.
        start_frame(2, 1'b1);
        tick();
        check("t3_err_width", int'(o_err), 0);
        check("t3_err_busy", int'(o_busy), 0);
        start_frame(513, 1'b1);
        tick();
        xfer_cnt = 0; done_cnt = 0; mark_first = 1'b1;
        exp_rows_q.push_back(1 + PAD_LINES);
        start_frame(3, 1'b0);
        fork
            source(3 * LINE_WIDTH, 0, 12'h0F0);
        join_none
        pulse_intr();
        check("t3_full_credit_intr", int'(o_rows_out), 0);
        wait_xfer(600, "t3_mid");
        i_frame_lines = LINE_CNT_W'(2);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("t3_busy_start_no_err", int'(o_err), 0);
        check("t3_busy_start_busy", int'(o_busy), 1);
        wait_xfer((3 + PAD_LINES) * LINE_WIDTH, "t3_all");
        repeat (3) tick();
        check("t3_waits_for_rows", done_cnt, 0);
        for (int r = 0; r < 1 + PAD_LINES; r++) pulse_intr();
        wait_done(1, "t3_done");
        repeat (3) tick();
        check("t3_queue_empty", exp_q.size(), 0);

        // 8-line frame with ~30% source gaps.
        run_frame(8, 30, 12'h5C3, 1'b0);

        // Reset in the middle of a frame.
        xfer_cnt = 0; done_cnt = 0; mark_first = 1'b1;
        exp_rows_q.push_back(3 + PAD_LINES);
        start_frame(5, 1'b0);
        fork
            source(5 * LINE_WIDTH, 0, 12'hA0A);
        join_none
        wait_xfer(600, "t5_pre");
        pulse_intr();
        check("t5_rows_before_rst", int'(o_rows_out), 1);
        wait_xfer(700, "t5_at700");
        abort = 1'b1;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("t5_rst_busy", int'(o_busy), 0);
        check("t5_rst_ready", int'(o_src_ready), 0);
        check("t5_rst_rows", int'(o_rows_out), 0);
        t = 0;
        while (src_active && t < 100) begin
            tick();
            t++;
        end
        check("t5_src_stopped", int'(src_active), 0);
        tick();
        exp_q.delete();
        exp_rows_q.delete();
        abort = 1'b0;
        check("t5_no_done", done_cnt, 0);
        run_frame(4, 0, 12'h777, 1'b1);

        check("final_rows_queue", exp_rows_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
